decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and register value width.
REQ-002 SHALL have parameter RADDR_W, default 5, register address width (32 registers).
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_instr_32 input 32, in_pc_32 input 32; fetch handshake.
REQ-006 SHALL have ports rf_s1_addr_5 output 5, rf_s2_addr_5 output 5, rf_s1_val_32 input 32, rf_s2_val_32 input 32; combinational register-file read.
REQ-007 SHALL have ports wb_en input 1, wb_addr_5 input 5, wb_data_32 input 32; writeback stage mirror of the register-file write port.
REQ-008 SHALL have port flush, input, 1, discard the in-flight decode and ID/EX contents (branch/jump taken).
REQ-009 SHALL have ports ex_valid output 1 and ex_ready input 1; execute handshake.
REQ-010 SHALL have registered outputs ex_s1_val_32, ex_s2_val_32, ex_imm_32, ex_pc_32 (32 each), ex_dest_5 (5), ex_opcode_6, ex_funct_6 (6 each), ex_reg_wen, ex_mem_read, ex_mem_write (1 each).
REQ-011 SHALL have output stall_cnt_16, 16, saturating count of load-use bubbles.

Function
REQ-012 SHALL decode opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0].
REQ-013 SHALL drive rf_s1_addr_5=rs and rf_s2_addr_5=rt combinationally from in_instr_32.
REQ-014 SHALL select dest: opcode 0x00 -> rd; 0x03 (JAL) -> 31; 0x23 (LW) and other I-type -> rt; 0x2B (SW), 0x04/0x05 (BEQ/BNE), 0x02 (J) -> no write.
REQ-015 SHALL force ex_reg_wen=0 whenever the selected dest is 0.
REQ-016 SHALL set ex_mem_read=1 only for 0x23 and ex_mem_write=1 only for 0x2B.
REQ-017 SHALL zero-extend imm for opcodes 0x0C/0x0D/0x0E and sign-extend for all others.
REQ-018 SHALL bypass: if wb_en=1, wb_addr_5!=0 and wb_addr_5==rs (rt), capture wb_data_32 instead of rf_s1_val_32 (rf_s2_val_32).
REQ-019 SHALL detect load-use hazard when ex_valid=1, ex_mem_read=1, ex_dest_5!=0, opcode not 0x02/0x03, and ex_dest_5 equals rs or rt.
REQ-020 SHALL on hazard: in_ready=0; if ex_ready=1, load a bubble (ex_valid=0) at the next edge and increment stall_cnt_16 (saturating at 0xFFFF).
REQ-021 SHALL hold all ex_* registers unchanged and drive in_ready=0 when ex_valid=1 and ex_ready=0.
REQ-022 SHALL otherwise drive in_ready=1 and, at an edge with in_valid=1, load decoded fields with ex_valid=1, latency one cycle.
REQ-023 SHALL load ex_valid=0 at an edge where in_ready=1 and in_valid=0.
REQ-024 SHALL on flush=1 drive in_ready=1, discard any offered instruction, clear ex_valid at the next edge and skip stall_cnt_16 increment; flush overrides hazard and hold.
REQ-025 SHALL apply bypass in the capture cycle only; held contents are not rewritten by later writebacks.

Reset
REQ-026 SHALL, while reset_n=0, clear ex_valid, all ex_* outputs and stall_cnt_16 to 0, independent of clock.
REQ-027 SHALL drop any instruction in flight when reset asserts mid-operation; first accept occurs at the first edge after release.

Structure
REQ-028 SHALL take opcode and funct constants (R-type, LW, SW, BEQ, BNE, J, JAL, ANDI, ORI, XORI) from shared package mips_pkg.
REQ-029 SHALL place the combinational decode (dest select, control bits, imm extension) in sub-module decode_ctrl; hazard, bypass and pipeline registers remain in decode_stage.

Verification
REQ-030 SHALL cover R-type: ADD rs=3 rt=4 rd=5 with rf values 3,4 -> next cycle ex_s1=3, ex_s2=4, ex_dest=5, ex_reg_wen=1.
REQ-031 SHALL cover bypass: ADD rs=7 with wb_en=1, wb_addr=7, wb_data=0xDEADBEEF same cycle -> ex_s1_val_32=0xDEADBEEF.
REQ-032 SHALL cover load-use: LW dest=8, then ADD rs=8 -> one cycle in_ready=0, one bubble, stall_cnt_16=1, ADD issued on the following cycle.
REQ-033 SHALL cover backpressure and flush: ex_ready=0 for 3 cycles -> ex_* stable and in_ready=0; flush=1 -> ex_valid=0 next cycle, stall_cnt_16 unchanged.
REQ-034 SHALL cover immediates and zero dest: ORI imm=0x8000 -> ex_imm=0x00008000; ADDI imm=0x8000 -> 0xFFFF8000; ADD rd=0 -> ex_reg_wen=0.
REQ-035 SHALL cover reset: reset_n low mid-stream -> all outputs 0 immediately and stall_cnt_16=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS encoding constants and small decode helpers.
// Contents: opcode/funct constants, destination-select enum,
//           helpers for destination class and immediate extension.
package mips_pkg;

  // Primary opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes, instruction bits [5:0]
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  // Link register written by JAL
  localparam logic [4:0] REG_RA = 5'd31;

  // Which instruction field (if any) names the register written back
  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RD   = 2'd1,
    DST_RT   = 2'd2,
    DST_RA   = 2'd3
  } dest_sel_e;

  function automatic dest_sel_e dest_sel_of(input logic [5:0] op);
    dest_sel_e sel;
    case (op)
      OP_RTYPE:                   sel = DST_RD;
      OP_JAL:                     sel = DST_RA;
      OP_SW, OP_BEQ, OP_BNE, OP_J: sel = DST_NONE;
      default:                    sel = DST_RT;
    endcase
    return sel;
  endfunction

  // Logical immediates are zero-extended; everything else sign-extends
  function automatic logic imm_is_zext(input logic [5:0] op);
    logic z;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: z = 1'b1;
      default:                  z = 1'b0;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// decode_ctrl: purely combinational field decode for the decode stage.
// Ports:
//   opcode_i, rt_i, rd_i, imm_i : instruction fields
//   dest_o      : destination register (0 when instruction writes nothing)
//   reg_wen_o   : register write enable (never set for destination 0)
//   mem_read_o  : LW
//   mem_write_o : SW
//   imm_o       : extended immediate
module decode_ctrl
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic [5:0]         opcode_i,
  input  logic [RADDR_W-1:0] rt_i,
  input  logic [RADDR_W-1:0] rd_i,
  input  logic [15:0]        imm_i,
  output logic [RADDR_W-1:0] dest_o,
  output logic               reg_wen_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [DATA_W-1:0]  imm_o
);

  dest_sel_e dest_sel_s;

  assign dest_sel_s = dest_sel_of(opcode_i);

  // Destination register selection
  always_comb begin
    dest_o = {RADDR_W{1'b0}};
    case (dest_sel_s)
      DST_RD:  dest_o = rd_i;
      DST_RT:  dest_o = rt_i;
      DST_RA:  dest_o = REG_RA;
      default: dest_o = {RADDR_W{1'b0}};
    endcase
  end

  // Writes to register 0 are architecturally dropped, so never enable them
  assign reg_wen_o   = (dest_sel_s != DST_NONE) && (dest_o != {RADDR_W{1'b0}});
  assign mem_read_o  = (opcode_i == OP_LW);
  assign mem_write_o = (opcode_i == OP_SW);

  // Immediate extension
  always_comb begin
    if (imm_is_zext(opcode_i)) begin
      imm_o = {{(DATA_W-16){1'b0}}, imm_i};
    end else begin
      imm_o = {{(DATA_W-16){imm_i[15]}}, imm_i};
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS-style instruction decode with ID/EX pipeline register.
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   in_valid/in_ready/in_*  : fetch handshake, instruction and PC
//   rf_s*_addr_5/rf_s*_val  : combinational register-file read
//   wb_en/wb_addr/wb_data   : writeback port mirror, used for bypass
//   flush                   : discard decode and ID/EX contents
//   ex_valid/ex_ready/ex_*  : execute handshake and registered payload
//   stall_cnt_16            : saturating count of load-use bubbles
module decode_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr_32,
  input  logic [31:0]        in_pc_32,
  output logic [RADDR_W-1:0] rf_s1_addr_5,
  output logic [RADDR_W-1:0] rf_s2_addr_5,
  input  logic [DATA_W-1:0]  rf_s1_val_32,
  input  logic [DATA_W-1:0]  rf_s2_val_32,
  input  logic               wb_en,
  input  logic [RADDR_W-1:0] wb_addr_5,
  input  logic [DATA_W-1:0]  wb_data_32,
  input  logic               flush,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [DATA_W-1:0]  ex_s1_val_32,
  output logic [DATA_W-1:0]  ex_s2_val_32,
  output logic [DATA_W-1:0]  ex_imm_32,
  output logic [31:0]        ex_pc_32,
  output logic [RADDR_W-1:0] ex_dest_5,
  output logic [5:0]         ex_opcode_6,
  output logic [5:0]         ex_funct_6,
  output logic               ex_reg_wen,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic [15:0]        stall_cnt_16
);

  logic [5:0]         opcode_s;
  logic [RADDR_W-1:0] rs_s, rt_s, rd_s, dest_s;
  logic [5:0]         funct_s;
  logic [15:0]        imm_field_s;
  logic [DATA_W-1:0]  imm_s, s1_s, s2_s;
  logic               reg_wen_s, mem_read_s, mem_write_s;
  logic               hazard_s, hold_s;

  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  s1_q, s1_d, s2_q, s2_d, imm_q, imm_d;
  logic [31:0]        pc_q, pc_d;
  logic [RADDR_W-1:0] dest_q, dest_d;
  logic [5:0]         op_q, op_d, fn_q, fn_d;
  logic               wen_q, wen_d, mrd_q, mrd_d, mwr_q, mwr_d;
  logic [15:0]        cnt_q, cnt_d;

  assign opcode_s    = in_instr_32[31:26];
  assign rs_s        = in_instr_32[25:21];
  assign rt_s        = in_instr_32[20:16];
  assign rd_s        = in_instr_32[15:11];
  assign funct_s     = in_instr_32[5:0];
  assign imm_field_s = in_instr_32[15:0];

  assign rf_s1_addr_5 = rs_s;
  assign rf_s2_addr_5 = rt_s;

  decode_ctrl #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W)
  ) u_ctrl (
    .opcode_i    (opcode_s),
    .rt_i        (rt_s),
    .rd_i        (rd_s),
    .imm_i       (imm_field_s),
    .dest_o      (dest_s),
    .reg_wen_o   (reg_wen_s),
    .mem_read_o  (mem_read_s),
    .mem_write_o (mem_write_s),
    .imm_o       (imm_s)
  );

  // Writeback bypass: the register file is read in the same cycle it is written
  assign s1_s = (wb_en && (wb_addr_5 != {RADDR_W{1'b0}}) && (wb_addr_5 == rs_s)) ? wb_data_32 : rf_s1_val_32;
  assign s2_s = (wb_en && (wb_addr_5 != {RADDR_W{1'b0}}) && (wb_addr_5 == rt_s)) ? wb_data_32 : rf_s2_val_32;

  // Load-use: a load in ID/EX whose destination feeds the offered instruction.
  // Qualified by in_valid so idle cycles are not counted as bubbles.
  assign hazard_s = in_valid && valid_q && mrd_q && (dest_q != {RADDR_W{1'b0}}) &&
                    (opcode_s != OP_J) && (opcode_s != OP_JAL) &&
                    ((dest_q == rs_s) || (dest_q == rt_s));

  assign hold_s = valid_q && !ex_ready;

  // Next-state selection: flush > hold > hazard bubble > accept/idle
  always_comb begin
    in_ready = 1'b1;
    valid_d  = valid_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    imm_d    = imm_q;
    pc_d     = pc_q;
    dest_d   = dest_q;
    op_d     = op_q;
    fn_d     = fn_q;
    wen_d    = wen_q;
    mrd_d    = mrd_q;
    mwr_d    = mwr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      in_ready = 1'b1;
      valid_d  = 1'b0;
      wen_d    = 1'b0;
      mrd_d    = 1'b0;
      mwr_d    = 1'b0;
    end else if (hold_s) begin
      in_ready = 1'b0;
    end else if (hazard_s) begin
      // Not holding here implies ex_ready=1, so the bubble advances
      in_ready = 1'b0;
      valid_d  = 1'b0;
      wen_d    = 1'b0;
      mrd_d    = 1'b0;
      mwr_d    = 1'b0;
      cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
    end else if (in_valid) begin
      in_ready = 1'b1;
      valid_d  = 1'b1;
      s1_d     = s1_s;
      s2_d     = s2_s;
      imm_d    = imm_s;
      pc_d     = in_pc_32;
      dest_d   = dest_s;
      op_d     = opcode_s;
      fn_d     = funct_s;
      wen_d    = reg_wen_s;
      mrd_d    = mem_read_s;
      mwr_d    = mem_write_s;
    end else begin
      in_ready = 1'b1;
      valid_d  = 1'b0;
      wen_d    = 1'b0;
      mrd_d    = 1'b0;
      mwr_d    = 1'b0;
    end
  end

  // ID/EX pipeline register and stall counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      s1_q    <= {DATA_W{1'b0}};
      s2_q    <= {DATA_W{1'b0}};
      imm_q   <= {DATA_W{1'b0}};
      pc_q    <= 32'd0;
      dest_q  <= {RADDR_W{1'b0}};
      op_q    <= 6'd0;
      fn_q    <= 6'd0;
      wen_q   <= 1'b0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      valid_q <= valid_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      dest_q  <= dest_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      wen_q   <= wen_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_s1_val_32 = s1_q;
  assign ex_s2_val_32 = s2_q;
  assign ex_imm_32    = imm_q;
  assign ex_pc_32     = pc_q;
  assign ex_dest_5    = dest_q;
  assign ex_opcode_6  = op_q;
  assign ex_funct_6   = fn_q;
  assign ex_reg_wen   = wen_q;
  assign ex_mem_read  = mrd_q;
  assign ex_mem_write = mwr_q;
  assign stall_cnt_16 = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage.
// The register file model returns each register's own index as its value.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr_32, in_pc_32;
  logic [4:0]  rf_s1_addr_5, rf_s2_addr_5;
  logic [31:0] rf_s1_val_32, rf_s2_val_32;
  logic        wb_en;
  logic [4:0]  wb_addr_5;
  logic [31:0] wb_data_32;
  logic        flush, ex_valid, ex_ready;
  logic [31:0] ex_s1_val_32, ex_s2_val_32, ex_imm_32, ex_pc_32;
  logic [4:0]  ex_dest_5;
  logic [5:0]  ex_opcode_6, ex_funct_6;
  logic        ex_reg_wen, ex_mem_read, ex_mem_write;
  logic [15:0] stall_cnt_16;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  assign rf_s1_val_32 = {27'd0, rf_s1_addr_5};
  assign rf_s2_val_32 = {27'd0, rf_s2_addr_5};

  decode_stage dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr_32(in_instr_32), .in_pc_32(in_pc_32),
    .rf_s1_addr_5(rf_s1_addr_5), .rf_s2_addr_5(rf_s2_addr_5),
    .rf_s1_val_32(rf_s1_val_32), .rf_s2_val_32(rf_s2_val_32),
    .wb_en(wb_en), .wb_addr_5(wb_addr_5), .wb_data_32(wb_data_32),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_s1_val_32(ex_s1_val_32), .ex_s2_val_32(ex_s2_val_32), .ex_imm_32(ex_imm_32),
    .ex_pc_32(ex_pc_32), .ex_dest_5(ex_dest_5), .ex_opcode_6(ex_opcode_6),
    .ex_funct_6(ex_funct_6), .ex_reg_wen(ex_reg_wen), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .stall_cnt_16(stall_cnt_16)
  );

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid    = v;
    in_instr_32 = instr;
    in_pc_32    = pc;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; offer(1'b0, 32'd0, 32'd0);
    wb_en = 1'b0; wb_addr_5 = 5'd0; wb_data_32 = 32'd0; flush = 1'b0; ex_ready = 1'b1;
    #2;
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0h want 0", ex_valid); end
    vectors++; if (stall_cnt_16 !== 16'd0) begin miscompares++; $display("FAIL reset_stall got %0h want 0", stall_cnt_16); end
    vectors++; if (ex_s1_val_32 !== 32'd0) begin miscompares++; $display("FAIL reset_s1 got %0h want 0", ex_s1_val_32); end
    vectors++; if (ex_reg_wen !== 1'b0) begin miscompares++; $display("FAIL reset_wen got %0h want 0", ex_reg_wen); end
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic test_rtype();
    offer(1'b1, enc_r(5'd3, 5'd4, 5'd5, 6'h20), 32'h100);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rtype_ready got %0h want 1", in_ready); end
    tick();
    offer(1'b0, 32'd0, 32'd0);
    vectors++; if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL rtype_valid got %0h want 1", ex_valid); end
    vectors++; if (ex_s1_val_32 !== 32'd3) begin miscompares++; $display("FAIL rtype_s1 got %0h want 3", ex_s1_val_32); end
    vectors++; if (ex_s2_val_32 !== 32'd4) begin miscompares++; $display("FAIL rtype_s2 got %0h want 4", ex_s2_val_32); end
    vectors++; if (ex_dest_5 !== 5'd5) begin miscompares++; $display("FAIL rtype_dest got %0h want 5", ex_dest_5); end
    vectors++; if (ex_reg_wen !== 1'b1) begin miscompares++; $display("FAIL rtype_wen got %0h want 1", ex_reg_wen); end
    vectors++; if (ex_funct_6 !== 6'h20) begin miscompares++; $display("FAIL rtype_funct got %0h want 20", ex_funct_6); end
    vectors++; if (ex_pc_32 !== 32'h100) begin miscompares++; $display("FAIL rtype_pc got %0h want 100", ex_pc_32); end
    tick();
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid got %0h want 0", ex_valid); end
  endtask

  task automatic test_bypass();
    offer(1'b1, enc_r(5'd7, 5'd2, 5'd9, 6'h20), 32'h104);
    wb_en = 1'b1; wb_addr_5 = 5'd7; wb_data_32 = 32'hDEADBEEF;
    tick();
    vectors++; if (ex_s1_val_32 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL bypass_s1 got %0h want deadbeef", ex_s1_val_32); end
    vectors++; if (ex_s2_val_32 !== 32'd2) begin miscompares++; $display("FAIL bypass_s2 got %0h want 2", ex_s2_val_32); end
    // held contents must not pick up a later writeback
    offer(1'b0, 32'd0, 32'd0); ex_ready = 1'b0; wb_data_32 = 32'h12345678;
    tick();
    vectors++; if (ex_s1_val_32 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL bypass_held got %0h want deadbeef", ex_s1_val_32); end
    ex_ready = 1'b1;
    // register 0 is never bypassed
    offer(1'b1, enc_r(5'd0, 5'd2, 5'd9, 6'h20), 32'h108);
    wb_addr_5 = 5'd0; wb_data_32 = 32'hFFFFFFFF;
    tick();
    vectors++; if (ex_s1_val_32 !== 32'd0) begin miscompares++; $display("FAIL bypass_r0 got %0h want 0", ex_s1_val_32); end
    wb_en = 1'b0; offer(1'b0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] instr_t [6];
    logic [31:0] imm_t [6];
    logic [4:0]  dest_t [6];
    logic        wen_t [6];
    logic        mrd_t [6];
    logic        mwr_t [6];
    instr_t[0] = enc_i(6'h0D, 5'd1, 5'd6, 16'h8000); imm_t[0] = 32'h00008000; dest_t[0] = 5'd6;  wen_t[0] = 1'b1; mrd_t[0] = 1'b0; mwr_t[0] = 1'b0;
    instr_t[1] = enc_i(6'h08, 5'd1, 5'd6, 16'h8000); imm_t[1] = 32'hFFFF8000; dest_t[1] = 5'd6;  wen_t[1] = 1'b1; mrd_t[1] = 1'b0; mwr_t[1] = 1'b0;
    instr_t[2] = enc_r(5'd1, 5'd2, 5'd0, 6'h20);     imm_t[2] = 32'h00000020; dest_t[2] = 5'd0;  wen_t[2] = 1'b0; mrd_t[2] = 1'b0; mwr_t[2] = 1'b0;
    instr_t[3] = enc_i(6'h2B, 5'd1, 5'd5, 16'hFFFC); imm_t[3] = 32'hFFFFFFFC; dest_t[3] = 5'd0;  wen_t[3] = 1'b0; mrd_t[3] = 1'b0; mwr_t[3] = 1'b1;
    instr_t[4] = enc_i(6'h03, 5'd0, 5'd0, 16'h0010); imm_t[4] = 32'h00000010; dest_t[4] = 5'd31; wen_t[4] = 1'b1; mrd_t[4] = 1'b0; mwr_t[4] = 1'b0;
    instr_t[5] = enc_i(6'h0C, 5'd2, 5'd0, 16'hF0F0); imm_t[5] = 32'h0000F0F0; dest_t[5] = 5'd0;  wen_t[5] = 1'b0; mrd_t[5] = 1'b0; mwr_t[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      offer(1'b1, instr_t[i], 32'h200 + 32'(i * 4));
      tick();
      vectors++; if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d] got %0h want 1", i, ex_valid); end
      vectors++; if (ex_imm_32 !== imm_t[i]) begin miscompares++; $display("FAIL b2b_imm[%0d] got %0h want %0h", i, ex_imm_32, imm_t[i]); end
      vectors++; if (ex_dest_5 !== dest_t[i]) begin miscompares++; $display("FAIL b2b_dest[%0d] got %0h want %0h", i, ex_dest_5, dest_t[i]); end
      vectors++; if (ex_reg_wen !== wen_t[i]) begin miscompares++; $display("FAIL b2b_wen[%0d] got %0h want %0h", i, ex_reg_wen, wen_t[i]); end
      vectors++; if ({ex_mem_read, ex_mem_write} !== {mrd_t[i], mwr_t[i]}) begin miscompares++; $display("FAIL b2b_mem[%0d] got %0h want %0h", i, {ex_mem_read, ex_mem_write}, {mrd_t[i], mwr_t[i]}); end
      vectors++; if (ex_opcode_6 !== instr_t[i][31:26]) begin miscompares++; $display("FAIL b2b_op[%0d] got %0h want %0h", i, ex_opcode_6, instr_t[i][31:26]); end
    end
    offer(1'b0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_load_use();
    offer(1'b1, enc_i(6'h23, 5'd1, 5'd8, 16'h0004), 32'h300);
    tick();
    vectors++; if (ex_mem_read !== 1'b1 || ex_dest_5 !== 5'd8) begin miscompares++; $display("FAIL lw_fields got rd=%0h dest=%0h want rd=1 dest=8", ex_mem_read, ex_dest_5); end
    offer(1'b1, enc_r(5'd8, 5'd2, 5'd10, 6'h20), 32'h304);
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL lu_ready got %0h want 0", in_ready); end
    tick();
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL lu_bubble got %0h want 0", ex_valid); end
    vectors++; if (stall_cnt_16 !== 16'd1) begin miscompares++; $display("FAIL lu_stall got %0h want 1", stall_cnt_16); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL lu_ready_after got %0h want 1", in_ready); end
    tick();
    vectors++; if (ex_valid !== 1'b1 || ex_dest_5 !== 5'd10 || ex_s1_val_32 !== 32'd8) begin miscompares++; $display("FAIL lu_issue got v=%0h dest=%0h s1=%0h want v=1 dest=a s1=8", ex_valid, ex_dest_5, ex_s1_val_32); end
    // J whose target bits alias rs=8 must not stall behind a load
    offer(1'b1, enc_i(6'h23, 5'd1, 5'd8, 16'h0004), 32'h308);
    tick();
    offer(1'b1, {6'h02, 5'd8, 5'd8, 16'h0040}, 32'h30C);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL lu_jump_ready got %0h want 1", in_ready); end
    tick();
    vectors++; if (ex_valid !== 1'b1 || ex_opcode_6 !== 6'h02 || ex_reg_wen !== 1'b0) begin miscompares++; $display("FAIL lu_jump got v=%0h op=%0h wen=%0h want v=1 op=2 wen=0", ex_valid, ex_opcode_6, ex_reg_wen); end
    vectors++; if (stall_cnt_16 !== 16'd1) begin miscompares++; $display("FAIL lu_jump_stall got %0h want 1", stall_cnt_16); end
    offer(1'b0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_backpressure_flush();
    offer(1'b1, enc_r(5'd3, 5'd4, 5'd5, 6'h20), 32'h400);
    tick();
    ex_ready = 1'b0;
    offer(1'b1, enc_r(5'd1, 5'd2, 5'd11, 6'h22), 32'h404);
    wb_en = 1'b1; wb_addr_5 = 5'd3; wb_data_32 = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d] got %0h want 0", i, in_ready); end
      tick();
      vectors++; if (ex_valid !== 1'b1 || ex_s1_val_32 !== 32'd3 || ex_dest_5 !== 5'd5 || ex_pc_32 !== 32'h400) begin miscompares++; $display("FAIL bp_hold[%0d] got v=%0h s1=%0h dest=%0h pc=%0h want v=1 s1=3 dest=5 pc=400", i, ex_valid, ex_s1_val_32, ex_dest_5, ex_pc_32); end
    end
    wb_en = 1'b0;
    flush = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %0h want 1", in_ready); end
    tick();
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %0h want 0", ex_valid); end
    vectors++; if (stall_cnt_16 !== 16'd1) begin miscompares++; $display("FAIL flush_stall got %0h want 1", stall_cnt_16); end
    flush = 1'b0; ex_ready = 1'b1;
    // flush beats a pending load-use hazard and does not count it
    offer(1'b1, enc_i(6'h23, 5'd1, 5'd8, 16'h0000), 32'h408);
    tick();
    offer(1'b1, enc_r(5'd2, 5'd8, 5'd12, 6'h20), 32'h40C);
    flush = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_hz_ready got %0h want 1", in_ready); end
    tick();
    vectors++; if (ex_valid !== 1'b0 || stall_cnt_16 !== 16'd1) begin miscompares++; $display("FAIL flush_hz got v=%0h cnt=%0h want v=0 cnt=1", ex_valid, stall_cnt_16); end
    flush = 1'b0; offer(1'b0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_reset_mid();
    offer(1'b1, enc_r(5'd3, 5'd4, 5'd5, 6'h20), 32'h500);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    vectors++; if (ex_valid !== 1'b0 || ex_s1_val_32 !== 32'd0 || ex_dest_5 !== 5'd0 || ex_pc_32 !== 32'd0) begin miscompares++; $display("FAIL rstmid_regs got v=%0h s1=%0h dest=%0h pc=%0h want all 0", ex_valid, ex_s1_val_32, ex_dest_5, ex_pc_32); end
    vectors++; if (stall_cnt_16 !== 16'd0 || ex_reg_wen !== 1'b0) begin miscompares++; $display("FAIL rstmid_cnt got cnt=%0h wen=%0h want 0", stall_cnt_16, ex_reg_wen); end
    tick();
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_edge got %0h want 0", ex_valid); end
    reset_n = 1'b1;
    tick();
    vectors++; if (ex_valid !== 1'b1 || ex_s1_val_32 !== 32'd3 || ex_pc_32 !== 32'h500) begin miscompares++; $display("FAIL rstmid_accept got v=%0h s1=%0h pc=%0h want v=1 s1=3 pc=500", ex_valid, ex_s1_val_32, ex_pc_32); end
    offer(1'b0, 32'd0, 32'd0);
    tick();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_bypass();
    test_back_to_back();
    test_load_use();
    test_backpressure_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
